// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sequencer: walks vec_out through every input combination
// in ascending order, samples y_in after a settle interval, and compares the
// captured table with a golden table latched at start.
// Optional macro TTS_ABORT_EN adds an abort input and an aborted status output.
module truth_table_sequencer #(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   y_in,
`ifdef TTS_ABORT_EN
    input  logic                   abort,
    output logic                   aborted,
`endif
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_fail_idx,
    output logic                   pass
);

    localparam int unsigned NVec = 1 << N_IN;
    localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned MmW  = N_IN + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VecLast = '1;

    if (SETTLE_CYC == 0) begin : gen_settle_chk
        $error("SETTLE_CYC must be at least 1");
    end
    if (N_IN < 1 || N_IN > 6) begin : gen_n_in_chk
        $error("N_IN must be in 1..6");
    end

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [NVec-1:0]   exp_q, exp_d;
    logic [NVec-1:0]   table_q, table_d;
    logic [MmW-1:0]    mm_q, mm_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    // Next-state and next-output computation for the whole sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        exp_d     = exp_q;
        table_d   = table_q;
        mm_d      = mm_q;
        ff_d      = ff_q;
        pass_d    = pass_q;
        aborted_d = aborted_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSettle;
                    exp_d     = expected;
                    vec_d     = '0;
                    cnt_d     = '0;
                    table_d   = '0;
                    mm_d      = '0;
                    ff_d      = '0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b0;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                table_d[vec_q] = y_in;
                if (y_in != exp_q[vec_q]) begin
                    mm_d = mm_q + MmW'(1);
                    // A zero count before this sample means this is the run's first miss
                    if (mm_q == '0) begin
                        ff_d = vec_q;
                    end
                end
                if (vec_q == VecLast) begin
                    state_d = StDone;
                    pass_d  = (mm_d == '0);
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef TTS_ABORT_EN
        // Abort discards this cycle's capture and returns to idle without a done pulse
        if (abort && (state_q == StSettle || state_q == StSample)) begin
            state_d   = StIdle;
            cnt_d     = cnt_q;
            vec_d     = vec_q;
            table_d   = table_q;
            mm_d      = mm_q;
            ff_d      = ff_q;
            pass_d    = pass_q;
            aborted_d = 1'b1;
        end
`endif

        busy_d = (state_d == StSettle) || (state_d == StSample);
        done_d = (state_d == StDone);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            vec_q     <= '0;
            exp_q     <= '0;
            table_q   <= '0;
            mm_q      <= '0;
            ff_q      <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            exp_q     <= exp_d;
            table_q   <= table_d;
            mm_q      <= mm_d;
            ff_q      <= ff_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign table_out      = table_q;
    assign mismatch_cnt   = mm_q;
    assign first_fail_idx = ff_q;
    assign pass           = pass_q;
`ifdef TTS_ABORT_EN
    assign aborted        = aborted_q;
`else
    logic unused_aborted;
    assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized self-checking bench for truth_table_sequencer (N_IN=3, SETTLE_CYC=2).
// The DUT under test is a random 8-entry lookup table driven from vec_out.
module tb_truth_table_sequencer;

    localparam int N      = 3;
    localparam int SETTLE = 2;
    localparam int RUNLEN = (1 << N) * (SETTLE + 1);

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] expected;
    logic       y_in;
    logic [2:0] vec_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_fail_idx;
    logic       pass;
`ifdef TTS_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    logic [7:0] dut_fn;
    int         n_checks;
    int         n_errors;

    truth_table_sequencer #(
        .N_IN       (N),
        .SETTLE_CYC (SETTLE)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .expected       (expected),
        .y_in           (y_in),
`ifdef TTS_ABORT_EN
        .abort          (abort),
        .aborted        (aborted),
`endif
        .vec_out        (vec_out),
        .busy           (busy),
        .done           (done),
        .table_out      (table_out),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
        .pass           (pass)
    );

    // Combinational block under test: a lookup table indexed by the drive vector
    assign y_in = dut_fn[vec_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popcnt8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int low_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    // y = (a & b) | c with a as the vector MSB
    function automatic logic [7:0] fn_abc();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = ((i >> 2) & (i >> 1) & 1) != 0 || (i & 1) != 0;
        return t;
    endfunction

    // One full run: start accepted at edge k, loop index c is cycle k+c
    task automatic run_check(input string tag, input logic [7:0] fn, input logic [7:0] ex,
                             input bit repulse);
        int busy_n;
        int done_n;
        int done_at;
        bit seq_ok;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        seq_ok  = 1'b1;
        dut_fn  = fn;
        @(negedge clk);
        start    = 1'b1;
        expected = ex;
        @(negedge clk);
        start    = 1'b0;
        expected = 8'($urandom);
        for (int c = 1; c <= RUNLEN + 6; c++) begin
            if (c > 1) @(negedge clk);
            start = repulse && (c == 5);
            if (busy) begin
                busy_n++;
                if (int'(vec_out) != (c - 1) / (SETTLE + 1)) seq_ok = 1'b0;
            end
            if (done) begin
                done_n++;
                done_at = c;
            end
        end
        start = 1'b0;
        check({tag, ".busy_cycles"}, busy_n, RUNLEN);
        check({tag, ".done_count"}, done_n, 1);
        check({tag, ".done_cycle"}, done_at, RUNLEN + 1);
        check({tag, ".vec_seq"}, 32'(seq_ok), 1);
        check({tag, ".table"}, table_out, fn);
        check({tag, ".mismatch"}, mismatch_cnt, popcnt8(fn ^ ex));
        check({tag, ".first_fail"}, first_fail_idx, low_idx(fn ^ ex));
        check({tag, ".pass"}, pass, 32'(fn == ex));
        check({tag, ".vec_hold"}, vec_out, 7);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".done_seen"}, 32'(done), 1);
    endtask

    initial begin
        logic [7:0] f;
        logic [7:0] e;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        expected = 8'h00;
        dut_fn   = 8'h00;
`ifdef TTS_ABORT_EN
        abort    = 1'b0;
`endif
        #1;
        check("reset.outputs",
              {vec_out, busy, done, table_out, mismatch_cnt, first_fail_idx, pass}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_check("exp_ea", fn_abc(), 8'hEA, 1'b0);
        run_check("exp_e8", fn_abc(), 8'hE8, 1'b0);
        run_check("exp_15", fn_abc(), 8'h15, 1'b0);
        run_check("restart_ignored", fn_abc(), 8'hEA, 1'b1);

        // Start held high: back-to-back runs with a single idle cycle between them
        dut_fn   = fn_abc();
        expected = 8'hEA;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done("hold.first", RUNLEN + 4);
        check("hold.first_pass", pass, 1);
        @(negedge clk);
        check("hold.gap_busy", {busy, done}, 0);
        @(negedge clk);
        check("hold.second_busy", busy, 1);
        check("hold.cleared", {table_out, mismatch_cnt, first_fail_idx, pass}, 0);
        start = 1'b0;
        wait_done("hold.second", RUNLEN + 4);
        @(negedge clk);

        // Asynchronous reset in the middle of a run
        dut_fn   = fn_abc();
        expected = 8'hEA;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.outputs",
              {vec_out, busy, done, table_out, mismatch_cnt, first_fail_idx, pass}, 0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done || busy) saw_done = 1'b1;
            end
            check("async_rst.quiet", 32'(saw_done), 0);
        end
        rst_n = 1'b1;
        run_check("after_rst", fn_abc(), 8'hEA, 1'b0);

`ifdef TTS_ABORT_EN
        dut_fn   = fn_abc();
        expected = 8'hEA;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int k;
            bit saw_done;
            k = 0;
            while (!(busy && vec_out == 3'd3) && k < RUNLEN) begin
                @(negedge clk);
                k++;
            end
            check("abort.reached_vec3", vec_out, 3);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort.idle", busy, 0);
            check("abort.flag", aborted, 1);
            saw_done = 1'b0;
            for (int i = 0; i < RUNLEN + 4; i++) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            check("abort.no_done", 32'(saw_done), 0);
            check("abort.pass", pass, 0);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort.cleared", aborted, 0);
        wait_done("abort.rerun", RUNLEN + 4);
        @(negedge clk);
`endif

        for (int r = 0; r < 8; r++) begin
            f = 8'($urandom);
            e = ($urandom_range(0, 2) == 0) ? f : (f ^ 8'($urandom));
            run_check($sformatf("rand%0d", r), f, e, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
